eth_rx_framer: RTL
==================

ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 SHALL have parameter MY_MAC, default 48'h00_10_8B_F1_F5_7E: station address accepted by the filter.
REQ-002 SHALL have parameter MAX_FRAME, default 11'd1518: maximum frame length in bytes, FCS included.
REQ-003 SHALL have port CLK  in  1: single clock for all logic; one clock domain only.
REQ-004 SHALL have port RST_N  in  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port RXD  in  8: GMII receive byte.
REQ-006 SHALL have port RX_DV  in  1: receive data valid.
REQ-007 SHALL have port RX_ER  in  1: receive error.
REQ-008 SHALL have port OUT_ETH_STREAM  out  10: {cke[9], frm[8], dat[7:0]}, the stream consumed by the packet engine.
REQ-009 SHALL have port FRAME_GOOD  out  1: one-cycle pulse, frame passed all checks.
REQ-010 SHALL have port FRAME_BAD  out  1: one-cycle pulse, forwarded frame failed a check.
REQ-011 SHALL have port RX_FRAME_CNT  out  16: count of FRAME_GOOD pulses.
REQ-012 SHALL have port RX_ERR_CNT  out  16: count of FRAME_BAD pulses plus dropped frames.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA, FLUSH, DROP.
REQ-014 IDLE->PREAMBLE when RX_DV=1 and RXD=8'h55; PREAMBLE->DATA on RXD=8'hD5 with RX_DV=1.
REQ-015 PREAMBLE->IDLE on RX_DV=0; PREAMBLE->DROP on any byte other than 8'h55/8'hD5.
REQ-016 DATA SHALL push each RXD byte into a 6-byte delay line and count bytes in an 11-bit counter.
REQ-017 First output byte (dest MAC byte 0) SHALL appear with cke=1, frm=1 on the cycle after the 7th post-SFD byte is sampled.
REQ-018 Thereafter one output byte per received byte, order preserved; cke=0 on all other cycles.
REQ-019 On RX_DV falling in DATA: ->FLUSH, emit the 2 oldest delay-line bytes on 2 consecutive cycles, discard the 4 FCS bytes.
REQ-020 frm SHALL stay 1 from first output byte through last flushed byte, then drop to 0 on the next cycle.
REQ-021 FRAME_GOOD or FRAME_BAD SHALL pulse on the same cycle frm falls; never both.
REQ-022 CRC: reflected poly 32'hEDB88320, init 32'hFFFFFFFF, over all post-SFD bytes incl FCS; good iff final register = 32'hDEBB20E3.
REQ-023 FRAME_BAD SHALL fire if CRC fails, RX_ER seen in DATA, or length (FCS incl) < 64.
REQ-024 Length reaching MAX_FRAME+1: ->DROP; if frm already 1, frm falls next cycle with FRAME_BAD.
REQ-025 Frame ending with fewer than 7 post-SFD bytes: no output, no pulse, RX_ERR_CNT +1, ->IDLE.
REQ-026 DROP SHALL emit nothing and return to IDLE when RX_DV=0.
REQ-027 RX_DV rising during FLUSH SHALL be ignored (no SFD hunt) until FLUSH completes and RX_DV returns to 0.
REQ-028 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-029 RST_N=0 SHALL immediately force OUT_ETH_STREAM=10'h000, FRAME_GOOD=0, FRAME_BAD=0, both counters 0, state IDLE, delay line and CRC cleared.
REQ-030 Reset mid-frame SHALL abort the frame with no pulse; after release, block waits for RX_DV=0 before hunting preamble.

Configuration
REQ-031 With ETH_RX_MAC_FILTER_EN defined: dest MAC not equal to MY_MAC or 48'hFFFF_FFFF_FFFF -> DROP before first output byte, RX_ERR_CNT +1.
REQ-032 Without ETH_RX_MAC_FILTER_EN: every frame forwarded regardless of dest MAC; MY_MAC unused.

Structure
REQ-033 Shared package eth_pkg SHALL hold preamble/SFD constants, CRC polynomial/init/residue, stream bit positions (CKE=9, FRM=8), state enum.
REQ-034 Byte-wise CRC update SHALL be a combinational sub-module eth_crc32_byte (crc_in, byte -> crc_out).

Verification
REQ-035 7x55,D5, 64-byte frame to MY_MAC, valid FCS -> 60 cke bytes, frm falls with FRAME_GOOD, RX_FRAME_CNT=1.
REQ-036 Same frame, one payload bit flipped -> 60 bytes forwarded, FRAME_BAD pulse, RX_ERR_CNT=1.
REQ-037 Filter on, dest 00_10_8B_F1_F5_7F -> no cke, no pulse, RX_ERR_CNT=1; filter off -> forwarded, FRAME_GOOD.
REQ-038 RX_ER=1 on byte 30 of 100-byte frame -> 96 bytes forwarded, FRAME_BAD.
REQ-039 1600-byte frame -> frm falls after byte 1519 received, FRAME_BAD, back-to-back valid frame (12-byte IPG) -> FRAME_GOOD.
REQ-040 RST_N low at byte 20 -> outputs 0 immediately; RX_DV held high after release -> no output until next preamble.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, state encoding and stream helpers for the GMII receive framer
//
// Purpose: single home for the framing bytes, the CRC-32 parameters, the
// bit layout of the 10-bit output stream and the framer state codes.
// Ports: none (package).
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Reflected CRC-32. Running the register over data plus its own FCS
  // (without final inversion) leaves the fixed residue below.
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Output stream layout: {cke, frm, dat[7:0]}
  localparam int          STREAM_W      = 10;
  localparam int          STREAM_CKE    = 9;
  localparam int          STREAM_FRM    = 8;

  // Shortest legal frame, FCS included
  localparam logic [10:0] MIN_FRAME     = 11'd64;
  // Depth of the delay line that hides the trailing FCS
  localparam logic [10:0] HDR_LAG       = 11'd6;

  // Framer states
  localparam logic [2:0]  ST_IDLE       = 3'd0;
  localparam logic [2:0]  ST_PREAMBLE   = 3'd1;
  localparam logic [2:0]  ST_DATA       = 3'd2;
  localparam logic [2:0]  ST_FLUSH      = 3'd3;
  localparam logic [2:0]  ST_DROP       = 3'd4;

  // Build an in-frame stream word carrying one data byte
  function automatic logic [STREAM_W-1:0] stream_word(input logic [7:0] data);
    logic [STREAM_W-1:0] w;
    w             = '0;
    w[STREAM_CKE] = 1'b1;
    w[STREAM_FRM] = 1'b1;
    w[7:0]        = data;
    return w;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - combinational one-byte update of the reflected Ethernet CRC-32
//
// Purpose: advance a CRC-32 register by one byte, LSB first.
// Ports:
//   crc_in    in  32  current register value
//   data_byte in  8   byte to fold in
//   crc_out   out 32  register value after the byte
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_framer.sv
// rtl/eth_rx_framer.sv - GMII receive framer: SFD hunt, FCS strip, CRC/length/error check
//
// Purpose: hunt preamble/SFD on a GMII byte stream, forward the frame body
// (FCS removed) on OUT_ETH_STREAM and flag each forwarded frame good or bad.
// Optional destination MAC filter: define ETH_RX_MAC_FILTER_EN.
// Ports:
//   CLK            in  1   single clock
//   RST_N          in  1   asynchronous active-low reset
//   RXD            in  8   GMII receive byte
//   RX_DV          in  1   receive data valid
//   RX_ER          in  1   receive error
//   OUT_ETH_STREAM out 10  {cke, frm, dat[7:0]}
//   FRAME_GOOD     out 1   pulse on frm fall, frame passed all checks
//   FRAME_BAD      out 1   pulse on frm fall, frame failed a check
//   RX_FRAME_CNT   out 16  saturating count of FRAME_GOOD pulses
//   RX_ERR_CNT     out 16  saturating count of FRAME_BAD pulses plus dropped frames
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h00_10_8B_F1_F5_7E,
  parameter logic [10:0] MAX_FRAME = 11'd1518
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  RXD,
  input  logic        RX_DV,
  input  logic        RX_ER,
  output logic [9:0]  OUT_ETH_STREAM,
  output logic        FRAME_GOOD,
  output logic        FRAME_BAD,
  output logic [15:0] RX_FRAME_CNT,
  output logic [15:0] RX_ERR_CNT
);

`ifdef ETH_RX_MAC_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  logic [2:0]      state;
  logic            hunt_ok;      // RX_DV seen low since the last frame activity
  logic [5:0][7:0] dline;        // dline[5] is the oldest byte
  logic [10:0]     byte_cnt;     // post-SFD bytes sampled so far
  logic [31:0]     crc;
  logic [31:0]     crc_next;
  logic            rx_err_seen;
  logic            flush_last;
  logic [9:0]      stream_q;
  logic            good_q;
  logic            bad_q;

  logic            started;
  logic            mac_hit;
  logic            mac_ok;
  logic            frame_ok;
  logic            good_evt;
  logic            bad_evt;
  logic            drop_evt;

  eth_crc32_byte u_crc (
    .crc_in    (crc),
    .data_byte (RXD),
    .crc_out   (crc_next)
  );

  // Output has started once the delay line has been full for one byte
  assign started  = (byte_cnt > HDR_LAG);

  // When the 7th byte arrives the delay line holds the destination MAC,
  // first byte in the most significant position.
  assign mac_hit  = (dline == MY_MAC) || (dline == 48'hFFFF_FFFF_FFFF);
  assign mac_ok   = mac_hit | ~FILTER_EN;

  assign frame_ok = (crc == CRC_RESIDUE) && !rx_err_seen && (byte_cnt >= MIN_FRAME);

  // Frame outcome events, registered into the pulses and counters together
  always_comb begin
    good_evt = 1'b0;
    bad_evt  = 1'b0;
    drop_evt = 1'b0;
    case (state)
      ST_DATA: begin
        if (RX_DV) begin
          if (byte_cnt == MAX_FRAME) begin
            bad_evt  = started;
            drop_evt = !started;
          end else if ((byte_cnt == HDR_LAG) && !mac_ok) begin
            drop_evt = 1'b1;
          end
        end else if (!started) begin
          drop_evt = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          good_evt = frame_ok;
          bad_evt  = !frame_ok;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      hunt_ok     <= 1'b0;
      dline       <= '0;
      byte_cnt    <= '0;
      crc         <= '0;
      rx_err_seen <= 1'b0;
      flush_last  <= 1'b0;
      stream_q    <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      stream_q <= '0;
      good_q   <= good_evt;
      bad_q    <= bad_evt;

      // A frame that starts while the previous one is still flushing has
      // lost its preamble, so it is skipped until the line goes idle.
      if (!RX_DV) begin
        hunt_ok <= 1'b1;
      end else if (state == ST_FLUSH) begin
        hunt_ok <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (hunt_ok && RX_DV && (RXD == PREAMBLE_BYTE)) begin
            state <= ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          if (!RX_DV) begin
            state <= ST_IDLE;
          end else if (RXD == SFD_BYTE) begin
            state       <= ST_DATA;
            byte_cnt    <= '0;
            crc         <= CRC_INIT;
            rx_err_seen <= 1'b0;
          end else if (RXD != PREAMBLE_BYTE) begin
            state <= ST_DROP;
          end
        end

        ST_DATA: begin
          if (RX_DV) begin
            if (byte_cnt == MAX_FRAME) begin
              state <= ST_DROP;
            end else begin
              byte_cnt <= byte_cnt + 11'd1;
              crc      <= crc_next;
              dline    <= {dline[4:0], RXD};
              if (RX_ER) begin
                rx_err_seen <= 1'b1;
              end
              if ((byte_cnt == HDR_LAG) && !mac_ok) begin
                state <= ST_DROP;
              end else if (byte_cnt >= HDR_LAG) begin
                stream_q <= stream_word(dline[5]);
              end
            end
          end else if (started) begin
            // Last byte is in; the newest four in the line are the FCS
            state      <= ST_FLUSH;
            flush_last <= 1'b0;
            stream_q   <= stream_word(dline[5]);
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_FLUSH: begin
          if (!flush_last) begin
            flush_last <= 1'b1;
            stream_q   <= stream_word(dline[4]);
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (!RX_DV) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RX_FRAME_CNT <= '0;
      RX_ERR_CNT   <= '0;
    end else begin
      if (good_evt && (RX_FRAME_CNT != 16'hFFFF)) begin
        RX_FRAME_CNT <= RX_FRAME_CNT + 16'd1;
      end
      if ((bad_evt || drop_evt) && (RX_ERR_CNT != 16'hFFFF)) begin
        RX_ERR_CNT <= RX_ERR_CNT + 16'd1;
      end
    end
  end

  assign OUT_ETH_STREAM = stream_q;
  assign FRAME_GOOD     = good_q;
  assign FRAME_BAD      = bad_q;

endmodule
